route_cntrl: RTL and testbench

ROUTE_CNTRL -- requirements
Module: route_cntrl

---
 rtl/route_pkg.sv | 29 ++
 rtl/route_cntrl_if.sv | 23 ++
 rtl/route_fifo.sv | 58 +++++
 rtl/route_cntrl.sv | 160 ++++++++++++++++
 tb/tb_route_cntrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/route_pkg.sv
// Shared types and defaults for the route controller: FSM state enum, opcodes,
// default parameter values and a counter-width helper.
package route_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DWELL  = 2'd2
  } state_e;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_GO     = 2'b01;
  localparam logic [1:0] OP_APPEND = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  localparam int CMD_W = 8;
  localparam int BC_W  = 8;

  localparam int ID_W_DEF      = 6;
  localparam int DEPTH_DEF     = 4;
  localparam int DWELL_CYC_DEF = 50000000;
  localparam int BUZZ_DIV_DEF  = 12500;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/route_cntrl_if.sv
// Command/barcode handshake bundle between the host side (master) and the
// route controller (slave), plus the obstacle input.
interface route_cntrl_if;

  logic [route_pkg::CMD_W-1:0] cmd;
  logic                        cmd_rdy;
  logic                        clr_cmd_rdy;
  logic [route_pkg::BC_W-1:0]  ID;
  logic                        ID_vld;
  logic                        clr_ID_vld;
  logic                        OK2Move;

  modport master (
    output cmd, cmd_rdy, ID, ID_vld, OK2Move,
    input  clr_cmd_rdy, clr_ID_vld
  );

  modport slave (
    input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
    output clr_cmd_rdy, clr_ID_vld
  );

endinterface

// File: rtl/route_fifo.sv
// Waypoint queue: power-of-two circular buffer with flush; flush together with
// push restarts the queue holding just the pushed entry.
module route_fifo
  import route_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [ID_W-1:0]            din,
  output logic [ID_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  // A pop in the same cycle frees the slot, so a full queue can still take a push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= push ? AW'(1) : '0;
      count <= push ? CW'(1) : '0;
    end else begin
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (flush & push)
      mem[0] <= din;
    else if (do_push)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/route_cntrl.sv
// Route sequencer: queues barcode waypoints, drives while moving, dwells at
// intermediate stops. Optional buzzer built only with ROUTE_CNTRL_BUZZ_EN.
module route_cntrl
  import route_pkg::*;
#(
  parameter int ID_W      = ID_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DWELL_CYC = DWELL_CYC_DEF,
  parameter int BUZZ_DIV  = BUZZ_DIV_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  route_cntrl_if.slave               bus,
  output logic                       in_transit,
  output logic                       go,
  output logic                       arrived,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] q_cnt,
  output logic                       buzz,
  output logic                       buzz_n
);

  // state  | meaning
  // IDLE   | no route, queue empty
  // MOVING | driving toward queue head
  // DWELL  | parked at an intermediate waypoint
  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_MOVING = 2'(ST_MOVING);
  localparam logic [1:0] S_DWELL  = 2'(ST_DWELL);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = cnt_w(DWELL_CYC);

  if (DEPTH < 2 || BUZZ_DIV < 2 || DWELL_CYC < 1 || ID_W < 1 || ID_W > 6) begin : g_bad_cfg
    $error("route_cntrl: unsupported parameter set");
  end

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [DW-1:0]   dwell_cnt;
  logic [1:0]      op;
  logic [ID_W-1:0] dest;
  logic [ID_W-1:0] q_head;
  logic            q_full;
  logic            q_push;
  logic            q_pop;
  logic            q_flush;
  logic            id_eval;
  logic            id_hit;
  logic            dwell_done;

  assign op   = bus.cmd[7:6];
  assign dest = bus.cmd[ID_W-1:0];

  assign bus.clr_cmd_rdy = bus.cmd_rdy & ~rst;
  // A command in MOVING defers the barcode by a cycle; elsewhere IDs are just discarded.
  assign bus.clr_ID_vld  = bus.ID_vld & ~((state == S_MOVING) & bus.cmd_rdy) & ~rst;

  assign id_eval    = (state == S_MOVING) & bus.ID_vld & ~bus.cmd_rdy;
  assign id_hit     = (bus.ID == BC_W'(q_head));
  assign dwell_done = (dwell_cnt == DW'(DWELL_CYC - 1));

  assign q_flush = bus.cmd_rdy & ((op == OP_STOP) | (op == OP_GO));
  assign q_push  = bus.cmd_rdy & ((op == OP_GO) | (op == OP_APPEND));
  assign q_pop   = id_eval & id_hit;

  route_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .din   (dest),
    .head  (q_head),
    .count (q_cnt),
    .full  (q_full)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.cmd_rdy && (op == OP_GO || op == OP_APPEND))
          state_nxt = S_MOVING;
      end
      S_MOVING: begin
        if (bus.cmd_rdy) begin
          if (op == OP_STOP)
            state_nxt = S_IDLE;
        end else if (q_pop) begin
          state_nxt = (q_cnt == CW'(1)) ? S_IDLE : S_DWELL;
        end
      end
      S_DWELL: begin
        if (bus.cmd_rdy && op == OP_STOP)
          state_nxt = S_IDLE;
        else if (bus.cmd_rdy && op == OP_GO)
          state_nxt = S_MOVING;
        else if (dwell_done)
          state_nxt = S_MOVING;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      arrived  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      arrived  <= q_pop & (q_cnt == CW'(1));
      overflow <= bus.cmd_rdy & (op == OP_APPEND) & q_full;
    end
  end

  // Held at zero outside DWELL so every entry starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dwell_cnt <= '0;
    else if (state != S_DWELL || state_nxt != S_DWELL)
      dwell_cnt <= '0;
    else
      dwell_cnt <= dwell_cnt + DW'(1);
  end

  assign in_transit = (state == S_MOVING);
  assign go         = in_transit & bus.OK2Move;

`ifdef ROUTE_CNTRL_BUZZ_EN
  localparam int BW = cnt_w(BUZZ_DIV);

  logic          buzz_en;
  logic          buzz_hi;
  logic [BW-1:0] buzz_cnt;

  assign buzz_en = in_transit & ~bus.OK2Move;
  assign buzz_hi = (buzz_cnt >= BW'(BUZZ_DIV / 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      buzz_cnt <= '0;
    else if (!buzz_en || buzz_cnt == BW'(BUZZ_DIV - 1))
      buzz_cnt <= '0;
    else
      buzz_cnt <= buzz_cnt + BW'(1);
  end

  assign buzz   = buzz_en & buzz_hi;
  assign buzz_n = buzz_en & ~buzz_hi;
`else
  assign buzz   = 1'b0;
  assign buzz_n = 1'b0;
`endif

endmodule

// File: tb/tb_route_cntrl.sv
// Directed + randomized bench for route_cntrl against a queue-based route model.
module tb_route_cntrl;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int BUZZ  = 8;
  localparam int M_IDLE = 0, M_MOV = 1, M_DWELL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_transit, go, arrived, overflow, buzz, buzz_n;
  logic [2:0] q_cnt;

  route_cntrl_if bus ();

  route_cntrl #(
    .ID_W      (6),
    .DEPTH     (DEPTH),
    .DWELL_CYC (DWELL),
    .BUZZ_DIV  (BUZZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .in_transit (in_transit),
    .go         (go),
    .arrived    (arrived),
    .overflow   (overflow),
    .q_cnt      (q_cnt),
    .buzz       (buzz),
    .buzz_n     (buzz_n)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int route[$];
  int mode       = M_IDLE;
  int dwell_left = 0;
  int run        = 0;
  bit m_arr      = 1'b0;
  bit m_ovf      = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a falling edge: drive, check against model, advance model one edge.
  task automatic step(input logic cr, input logic [7:0] c, input logic iv,
                      input logic [7:0] i, input logic ok);
    int  op, dest, start;
    bit  en, bz;
    bus.cmd_rdy = cr; bus.cmd = c; bus.ID_vld = iv; bus.ID = i; bus.OK2Move = ok;
    #1;
    en = (mode == M_MOV) && !ok;
    bz = en && ((run % BUZZ) >= BUZZ / 2);
    chk("clr_cmd_rdy", 8'(bus.clr_cmd_rdy), 8'(cr));
    chk("clr_ID_vld",  8'(bus.clr_ID_vld),  8'(iv && !(mode == M_MOV && cr)));
    chk("in_transit",  8'(in_transit),      8'(mode == M_MOV));
    chk("go",          8'(go),              8'(mode == M_MOV && ok));
    chk("arrived",     8'(arrived),         8'(m_arr));
    chk("overflow",    8'(overflow),        8'(m_ovf));
    chk("q_cnt",       8'(q_cnt),           8'(route.size()));
`ifdef ROUTE_CNTRL_BUZZ_EN
    chk("buzz",        8'(buzz),            8'(bz));
    chk("buzz_n",      8'(buzz_n),          8'(en && !bz));
`else
    chk("buzz",        8'(buzz),            8'(0));
    chk("buzz_n",      8'(buzz_n),          8'(0));
`endif
    run   = en ? run + 1 : 0;
    op    = int'(c[7:6]);
    dest  = int'(c[5:0]);
    start = mode;
    m_arr = 1'b0;
    m_ovf = 1'b0;
    if (cr && op == 0) begin
      route.delete();
      mode = M_IDLE;
    end else if (cr && op == 1) begin
      route.delete();
      route.push_back(dest);
      mode = M_MOV;
    end else begin
      if (cr && op == 2) begin
        if (route.size() == DEPTH) m_ovf = 1'b1;
        else begin
          route.push_back(dest);
          if (start == M_IDLE) mode = M_MOV;
        end
      end
      if (start == M_DWELL) begin
        dwell_left--;
        if (dwell_left == 0) mode = M_MOV;
      end
      if (start == M_MOV && !cr && iv && route.size() > 0 && int'(i) == route[0]) begin
        void'(route.pop_front());
        if (route.size() == 0) begin
          mode  = M_IDLE;
          m_arr = 1'b1;
        end else begin
          mode       = M_DWELL;
          dwell_left = DWELL;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ok);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 8'h00, ok);
  endtask

  // Asynchronous reset asserted mid-cycle with handshakes pending; everything must read 0.
  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_rdy = 1'b1; bus.cmd = 8'h41; bus.ID_vld = 1'b1; bus.ID = 8'h01; bus.OK2Move = 1'b0;
    #1;
    chk("rst_clr_cmd_rdy", 8'(bus.clr_cmd_rdy), 8'(0));
    chk("rst_clr_ID_vld",  8'(bus.clr_ID_vld),  8'(0));
    chk("rst_in_transit",  8'(in_transit),      8'(0));
    chk("rst_go",          8'(go),              8'(0));
    chk("rst_arrived",     8'(arrived),         8'(0));
    chk("rst_overflow",    8'(overflow),        8'(0));
    chk("rst_q_cnt",       8'(q_cnt),           8'(0));
    chk("rst_buzz",        8'(buzz),            8'(0));
    chk("rst_buzz_n",      8'(buzz_n),          8'(0));
    route.delete();
    mode = M_IDLE; dwell_left = 0; run = 0; m_arr = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic       cr, iv, ok;
    logic [7:0] c, i;
    bus.cmd_rdy = 1'b0; bus.cmd = 8'h00; bus.ID_vld = 1'b0; bus.ID = 8'h00; bus.OK2Move = 1'b1;
    @(negedge clk);
    do_reset();

    // GO dest 5 then barcode 5: single-stop route, arrival
    step(1'b1, 8'h45, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h05, 1'b1);
    idle(2, 1'b1);

    // Two-stop route with dwell; a non-matching and non-zero-extended ID first
    step(1'b1, 8'h43, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h87, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h43, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h03, 1'b1);
    idle(5, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h07, 1'b1);
    idle(1, 1'b1);

    // Overflow on the fourth APPEND after GO
    step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    for (int k = 2; k <= 5; k++) step(1'b1, 8'h80 | 8'(k), 1'b0, 8'h00, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);

    // Obstacle while moving: buzzer sequence, then clear
    step(1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
    idle(10, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 8'hC0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);

    // STOP and matching ID together: command wins, ID discarded next cycle
    step(1'b1, 8'h46, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h06, 1'b1, 8'h06, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h06, 1'b1);
    idle(1, 1'b1);

    // Reset mid-dwell with two entries left, then immediate command after release
    step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h82, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h83, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
    idle(1, 1'b1);
    do_reset();
    step(1'b1, 8'h49, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cr = ($urandom_range(0, 99) < 25);
        c  = {2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7))};
        iv = ($urandom_range(0, 99) < 40);
        if (route.size() > 0 && $urandom_range(0, 1) == 1) i = 8'(route[0]);
        else if ($urandom_range(0, 9) == 0) i = 8'($urandom_range(0, 255));
        else i = 8'($urandom_range(0, 7));
        ok = ($urandom_range(0, 99) < 75);
        step(cr, c, iv, i, ok);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
